// File: rtl/bit_deser32.sv
// Serial-to-parallel word assembler: one bit per accepted beat is written into a
// 32-bit word at a counter-selected position; completed or flushed words are handed off.
module bit_deser32 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_count,
  output logic [4:0]  bit_idx
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [4:0] FIRST_IDX = MSB_FIRST ? 5'd31 : 5'd0;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] data;
  logic        out_valid_q;
  logic        in_fire;
  logic        out_fire;
  logic        word_done;
  logic [31:0] data_wr;
  logic [31:0] data_fresh;

  assign bit_idx  = MSB_FIRST ? (5'd31 - cnt[4:0]) : cnt[4:0];
  assign in_ready = (state == FILL) | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // A word closes on the 32nd bit, or on flush when it holds (or is about to hold) a bit.
  assign word_done = (in_fire && (cnt == 6'd31)) ||
                     (flush && (in_fire || (cnt != 6'd0)));

  always_comb begin
    data_wr          = data;
    data_wr[bit_idx] = in_bit;
  end

  // Word seeded by a bit accepted on the same edge the previous word is consumed.
  always_comb begin
    data_fresh            = '0;
    data_fresh[FIRST_IDX] = in_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      data        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_fire) begin
            data <= data_wr;
            cnt  <= cnt + 6'd1;
          end
          if (word_done) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            if (in_fire) begin
              data <= data_fresh;
              cnt  <= 6'd1;
            end else begin
              data <= '0;
              cnt  <= '0;
            end
            state       <= FILL;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data;
  assign out_count = cnt;

endmodule

// File: tb/tb_bit_deser32.sv
// Scoreboard bench for bit_deser32: an LSB-first instance carries most traffic,
// an MSB-first instance checks the reversed bit ordering.
module tb_bit_deser32;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid0 = 1'b0, in_bit0 = 1'b0, flush0 = 1'b0, out_ready0 = 1'b0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [5:0]  out_count0;
  logic [4:0]  bit_idx0;

  logic        in_valid1 = 1'b0, in_bit1 = 1'b0, flush1 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [5:0]  out_count1;
  logic [4:0]  bit_idx1;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   outs0 = 0;

  always #5 clk = ~clk;

  bit_deser32 #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_bit(in_bit0), .in_ready(in_ready0),
    .flush(flush0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_count(out_count0), .bit_idx(bit_idx0)
  );

  bit_deser32 #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_bit(in_bit1), .in_ready(in_ready1),
    .flush(flush1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_count(out_count1), .bit_idx(bit_idx1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop on every handshake and compare word and count.
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      outs0++;
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out0: got %h/%0d expected no output", out_data0, out_count0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("out_data0", out_data0, e.d);
        chk("out_count0", {26'd0, out_count0}, {26'd0, e.c});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out1: got %h/%0d expected no output", out_data1, out_count1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("out_data1", out_data1, e.d);
        chk("out_count1", {26'd0, out_count1}, {26'd0, e.c});
      end
    end
  end

  task automatic step0(input logic v, input logic b, input logic f, input logic ordy);
    in_valid0 = v; in_bit0 = b; flush0 = f; out_ready0 = ordy;
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic v, input logic b, input logic f, input logic ordy);
    in_valid1 = v; in_bit1 = b; flush1 = f; out_ready1 = ordy;
    @(posedge clk); #1;
  endtask

  task automatic send_word0(input logic [31:0] w, input logic ordy);
    for (int i = 0; i < 32; i++) step0(1'b1, w[i], 1'b0, ordy);
  endtask

  task automatic push0(input logic [31:0] d, input logic [5:0] c);
    exp_t e;
    e.d = d; e.c = c;
    q0.push_back(e);
  endtask

  initial begin
    exp_t e1;
    logic [31:0] words [3];
    int outs_before;
    words[0] = 32'h0000_0001;
    words[1] = 32'h8000_0000;
    words[2] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_out_data", out_data0, 32'd0);
    chk("rst_out_count", {26'd0, out_count0}, 32'd0);
    chk("rst_bit_idx0", {27'd0, bit_idx0}, 32'd0);
    chk("rst_bit_idx1", {27'd0, bit_idx1}, 32'd31);
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);

    // Full LSB-first word, consumer always ready
    push0(32'hA5A5_0F3C, 6'd32);
    send_word0(32'hA5A5_0F3C, 1'b1);
    chk("full_valid_after_32", {31'd0, out_valid0}, 32'd1);
    step0(1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_valid_one_cycle", {31'd0, out_valid0}, 32'd0);

    // MSB-first partial word closed by flush
    e1.d = 32'hB000_0000; e1.c = 6'd4;
    q1.push_back(e1);
    chk("msb_idx_b0", {27'd0, bit_idx1}, 32'd31);
    step1(1'b1, 1'b1, 1'b0, 1'b0);
    chk("msb_idx_b1", {27'd0, bit_idx1}, 32'd30);
    step1(1'b1, 1'b0, 1'b0, 1'b0);
    chk("msb_idx_b2", {27'd0, bit_idx1}, 32'd29);
    step1(1'b1, 1'b1, 1'b0, 1'b0);
    chk("msb_idx_b3", {27'd0, bit_idx1}, 32'd28);
    step1(1'b1, 1'b1, 1'b0, 1'b0);
    chk("msb_idx_b4", {27'd0, bit_idx1}, 32'd27);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("msb_flush_valid", {31'd0, out_valid1}, 32'd1);
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: full word held while input keeps offering a 0 bit
    push0(32'hFFFF_FFFF, 6'd32);
    send_word0(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid0 = 1'b1; in_bit0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b0;
      #1;
      chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid0}, 32'd1);
      chk("bp_out_data", out_data0, 32'hFFFF_FFFF);
      chk("bp_out_count", {26'd0, out_count0}, 32'd32);
      @(posedge clk); #1;
    end
    step0(1'b1, 1'b0, 1'b0, 1'b1);
    chk("bp_bit_idx", {27'd0, bit_idx0}, 32'd1);
    chk("bp_valid_clear", {31'd0, out_valid0}, 32'd0);
    push0(32'hFFFF_FFFE, 6'd32);
    for (int i = 1; i < 32; i++) step0(1'b1, 1'b1, 1'b0, 1'b1);
    step0(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush on empty word is ignored; flush with the first bit closes a 1-bit word
    step0(1'b0, 1'b0, 1'b1, 1'b1);
    step0(1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_empty_valid", {31'd0, out_valid0}, 32'd0);
    chk("flush_empty_idx", {27'd0, bit_idx0}, 32'd0);
    push0(32'h0000_0001, 6'd1);
    step0(1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_first_valid", {31'd0, out_valid0}, 32'd1);
    chk("flush_first_count", {26'd0, out_count0}, 32'd1);
    step0(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset after 17 bits discards the partial word
    for (int i = 0; i < 17; i++) step0(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step0(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_mid_idx", {27'd0, bit_idx0}, 32'd0);
    push0(32'h1234_5678, 6'd32);
    send_word0(32'h1234_5678, 1'b1);
    step0(1'b0, 1'b0, 1'b0, 1'b1);

    // Three back-to-back words with no bubbles
    outs_before = outs0;
    for (int w = 0; w < 3; w++) push0(words[w], 6'd32);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 32; i++) begin
        in_valid0 = 1'b1; in_bit0 = words[w][i]; flush0 = 1'b0; out_ready0 = 1'b1;
        #1;
        if (!in_ready0) begin
          total++; bad++;
          $display("FAIL b2b_in_ready: got 0 expected 1 at word %0d bit %0d", w, i);
        end
        @(posedge clk); #1;
      end
    end
    total++;
    step0(1'b0, 1'b0, 1'b0, 1'b1);
    step0(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_out_count", outs0 - outs_before, 32'd3);

    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
